// File: rtl/cr16_run_ctrl_pkg.sv
// Shared types for the CR16 run-control sequencer: FSM states, run modes
// and the debug encodings shown on the O_STATE LEDs.
package cr16_run_ctrl_pkg;

    // Debug encodings driven on O_STATE.
    localparam logic [2:0] OSTATE_COLD      = 3'd0;
    localparam logic [2:0] OSTATE_RUN       = 3'd1;
    localparam logic [2:0] OSTATE_STEP_WAIT = 3'd2;
    localparam logic [2:0] OSTATE_STEP_EXEC = 3'd3;
    localparam logic [2:0] OSTATE_HALT      = 3'd4;

    // Sequencer states; the encoding doubles as the O_STATE value.
    typedef enum logic [2:0] {
        ST_COLD      = OSTATE_COLD,
        ST_RUN       = OSTATE_RUN,
        ST_STEP_WAIT = OSTATE_STEP_WAIT,
        ST_STEP_EXEC = OSTATE_STEP_EXEC,
        ST_HALT      = OSTATE_HALT
    } state_e;

    // Run modes selected by I_RUN_MODE.
    typedef enum logic [1:0] {
        RUN_FREE  = 2'b00,
        RUN_STEP  = 2'b01,
        RUN_BREAK = 2'b10
    } mode_e;

    // The unused mode code 2'b11 behaves exactly like free-run.
    function automatic mode_e decode_run_mode(input logic [1:0] raw);
        mode_e mode;
        case (raw)
            2'b01:   mode = RUN_STEP;
            2'b10:   mode = RUN_BREAK;
            default: mode = RUN_FREE;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/cr16_run_ctrl_sync_rise_detect.sv
// sync_rise_detect: multi-flop synchroniser for an asynchronous level,
// followed by a registered rising-edge detector producing a one-cycle pulse.
// With two sync stages the pulse appears on the 3rd clock edge after the
// input rises.
module sync_rise_detect #(
    parameter int P_STAGES = 2
) (
    input  logic I_CLK,
    input  logic I_NRESET,
    input  logic I_ASYNC,
    output logic O_PULSE
);

    logic [P_STAGES-1:0] sync_reg;
    logic [P_STAGES-1:0] sync_next;
    logic                sync_d_reg;
    logic                pulse_reg;

    // Each stage takes the previous one; stage 0 takes the raw input.
    genvar gi;
    generate
        for (gi = 0; gi < P_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = I_ASYNC;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    // Synchroniser chain, delayed copy and registered rising-edge pulse.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            sync_reg   <= '0;
            sync_d_reg <= 1'b0;
            pulse_reg  <= 1'b0;
        end else begin
            sync_reg   <= sync_next;
            sync_d_reg <= sync_reg[P_STAGES-1];
            pulse_reg  <= sync_reg[P_STAGES-1] & ~sync_d_reg;
        end
    end

    assign O_PULSE = pulse_reg;

endmodule

// File: rtl/cr16_run_ctrl.sv
// cr16_run_ctrl: run-control sequencer between the BRAM/CR16 top level and
// the CR16 core. Holds the core off during BRAM warm-up, then runs it in
// free-run, single-step or run-to-breakpoint mode, halts past a PC limit and
// drives the 7-segment display word. The core is gated through a synchronous
// enable instead of a gated clock.
// Optional feature macro: CR16_RUN_CTRL_CYCLE_COUNT_EN (enabled-cycle counter
// on O_CYCLE_COUNT, shown on display digits [5:4] while halted).
module cr16_run_ctrl
    import cr16_run_ctrl_pkg::*;
#(
    parameter logic [15:0] P_COLD_CLK_CYCLES = 16'd1,
    parameter logic [15:0] P_MAX_PC          = 16'd20,
    parameter int          P_PC_WIDTH        = 16,
    parameter int          P_DATA_WIDTH      = 16,
    parameter int          P_NUM_DIGITS      = 6
) (
    input  logic                      I_CLK,
    input  logic                      I_NRESET,
    input  logic [1:0]                I_RUN_MODE,
    input  logic                      I_STEP,
    input  logic [P_PC_WIDTH-1:0]     I_BREAK_PC,
    input  logic [P_PC_WIDTH-1:0]     I_PC,
    input  logic [P_DATA_WIDTH-1:0]   I_RESULT_BUS,
    input  logic [P_DATA_WIDTH-1:0]   I_MEM_DATA_B,
    output logic                      O_CR16_ENABLE,
    output logic [2:0]                O_STATE,
    output logic [4*P_NUM_DIGITS-1:0] O_DISPLAY_BITS
`ifdef CR16_RUN_CTRL_CYCLE_COUNT_EN
    ,
    output logic [31:0]               O_CYCLE_COUNT
`endif
);

    localparam int                    DW       = 4 * P_NUM_DIGITS;
    localparam logic [P_PC_WIDTH-1:0] MAX_PC_W = P_PC_WIDTH'(P_MAX_PC);

    state_e          state_reg,   state_next;
    logic [15:0]     cold_cnt_reg, cold_cnt_next;
    logic            bp_mask_reg, bp_mask_next;
    logic [DW-1:0]   display_reg, display_next, display_base;
    mode_e           run_mode;
    logic            step_pulse;
    logic            pc_over;
    logic            bp_hit;
    logic            halt_cond;
    logic            core_enable;

    // Step button: synchronise the asynchronous level and turn its rising
    // edge into a one-cycle pulse.
    sync_rise_detect #(
        .P_STAGES (2)
    ) u_step_sync (
        .I_CLK    (I_CLK),
        .I_NRESET (I_NRESET),
        .I_ASYNC  (I_STEP),
        .O_PULSE  (step_pulse)
    );

    // Mode is quasi-static, so it is decoded directly without synchronisation.
    assign run_mode = decode_run_mode(I_RUN_MODE);

    // Halt condition: PC past the limit, or an unmasked breakpoint hit.
    always_comb begin
        pc_over   = (I_PC > MAX_PC_W);
        bp_hit    = (run_mode == RUN_BREAK) && (I_PC == I_BREAK_PC) && !bp_mask_reg;
        halt_cond = pc_over | bp_hit;
    end

    // Core enable drops in the same cycle the halt condition appears, so the
    // core never executes an instruction past the limit or breakpoint.
    assign core_enable   = ((state_reg == ST_RUN) || (state_reg == ST_STEP_EXEC)) && !halt_cond;
    assign O_CR16_ENABLE = core_enable;
    assign O_STATE       = state_reg;

    // State, warm-up counter, breakpoint mask and display registers.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_reg    <= ST_COLD;
            cold_cnt_reg <= 16'd0;
            bp_mask_reg  <= 1'b0;
            display_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cold_cnt_reg <= cold_cnt_next;
            bp_mask_reg  <= bp_mask_next;
            display_reg  <= display_next;
        end
    end

    // Next-state logic. The breakpoint mask is only raised when resuming out
    // of HALT and lasts for exactly the single STEP_EXEC cycle that follows.
    always_comb begin
        state_next    = state_reg;
        cold_cnt_next = cold_cnt_reg;
        bp_mask_next  = 1'b0;
        case (state_reg)
            ST_COLD: begin
                if (cold_cnt_reg == P_COLD_CLK_CYCLES) begin
                    state_next = (run_mode == RUN_STEP) ? ST_STEP_WAIT : ST_RUN;
                end else begin
                    cold_cnt_next = cold_cnt_reg + 16'd1;
                end
            end
            ST_RUN: begin
                if (halt_cond) begin
                    state_next = ST_HALT;
                end else if (run_mode == RUN_STEP) begin
                    state_next = ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (run_mode != RUN_STEP) begin
                    state_next = ST_RUN;
                end else if (step_pulse) begin
                    state_next = ST_STEP_EXEC;
                end
            end
            ST_STEP_EXEC: begin
                if (halt_cond) begin
                    state_next = ST_HALT;
                end else if (run_mode != RUN_STEP) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_STEP_WAIT;
                end
            end
            ST_HALT: begin
                // Past the PC limit the halt is sticky until reset.
                if (step_pulse && !pc_over) begin
                    state_next   = ST_STEP_EXEC;
                    bp_mask_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_COLD;
            end
        endcase
    end

    // Display source: BRAM port-B data when halted past the limit, otherwise
    // PC and result bus side by side, truncated or padded to the digit count.
    always_comb begin
        if ((state_reg == ST_HALT) && pc_over) begin
            display_base = DW'(I_MEM_DATA_B);
        end else begin
            display_base = DW'({I_PC, I_RESULT_BUS});
        end
    end

`ifdef CR16_RUN_CTRL_CYCLE_COUNT_EN
    logic [31:0] cycle_count_reg;

    // Count enabled core cycles, saturating at all-ones.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            cycle_count_reg <= 32'd0;
        end else if (core_enable && (cycle_count_reg != 32'hFFFF_FFFF)) begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
        end
    end

    assign O_CYCLE_COUNT = cycle_count_reg;

    generate
        if (P_NUM_DIGITS >= 6) begin : g_cnt_digits
            // While halted, digits [5:4] show the low byte of the cycle count.
            always_comb begin
                display_next = display_base;
                if (state_reg == ST_HALT) begin
                    display_next[23:16] = cycle_count_reg[7:0];
                end
            end
        end else begin : g_no_cnt_digits
            assign display_next = display_base;
        end
    endgenerate
`else
    assign display_next = display_base;
`endif

    assign O_DISPLAY_BITS = display_reg;

endmodule

// File: tb/tb_cr16_run_ctrl.sv
// Testbench for cr16_run_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized episodes checked every cycle against
// a behavioural reference model.
module tb_cr16_run_ctrl;

    localparam int MAX_PC = 20;
    localparam int COLD   = 1;

    logic        I_CLK = 1'b0;
    logic        I_NRESET = 1'b0;
    logic [1:0]  I_RUN_MODE = 2'b00;
    logic        I_STEP = 1'b0;
    logic [15:0] I_BREAK_PC = 16'h0;
    logic [15:0] I_PC = 16'h0;
    logic [15:0] I_RESULT_BUS = 16'h0;
    logic [15:0] I_MEM_DATA_B = 16'h0;
    logic        O_CR16_ENABLE;
    logic [2:0]  O_STATE;
    logic [23:0] O_DISPLAY_BITS;
`ifdef CR16_RUN_CTRL_CYCLE_COUNT_EN
    logic [31:0] O_CYCLE_COUNT;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 I_CLK = ~I_CLK;

    cr16_run_ctrl dut (
        .I_CLK          (I_CLK),
        .I_NRESET       (I_NRESET),
        .I_RUN_MODE     (I_RUN_MODE),
        .I_STEP         (I_STEP),
        .I_BREAK_PC     (I_BREAK_PC),
        .I_PC           (I_PC),
        .I_RESULT_BUS   (I_RESULT_BUS),
        .I_MEM_DATA_B   (I_MEM_DATA_B),
        .O_CR16_ENABLE  (O_CR16_ENABLE),
        .O_STATE        (O_STATE),
        .O_DISPLAY_BITS (O_DISPLAY_BITS)
`ifdef CR16_RUN_CTRL_CYCLE_COUNT_EN
        ,
        .O_CYCLE_COUNT  (O_CYCLE_COUNT)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge I_CLK);
    endtask

    // ---------------- behavioural reference model ----------------
    // Phases are numbered by their O_STATE values: 0 cold, 1 run,
    // 2 waiting for a step, 3 executing one step, 4 halted.
    int          m_phase;
    int          m_cold_seen;   // cycles already spent warming up
    bit          m_mask;        // breakpoint ignored in this cycle
    logic [3:0]  m_hist;        // I_STEP as sampled at the last 4 edges, [0] newest
    logic [23:0] m_disp;
    logic [31:0] m_count;

    function automatic int eff_mode();
        return (I_RUN_MODE == 2'b11) ? 0 : int'(I_RUN_MODE);
    endfunction

    // The button press is seen two sampled edges late, for exactly one cycle.
    function automatic bit m_pulse();
        return m_hist[2] && !m_hist[3];
    endfunction

    function automatic bit m_halt();
        return (int'(I_PC) > MAX_PC) || (eff_mode() == 2 && I_PC == I_BREAK_PC && !m_mask);
    endfunction

    function automatic bit m_enable();
        return (m_phase == 1 || m_phase == 3) && !m_halt();
    endfunction

    function automatic int m_next_phase();
        int md = eff_mode();
        case (m_phase)
            0: return (m_cold_seen == COLD) ? ((md == 1) ? 2 : 1) : 0;
            1: return m_halt() ? 4 : ((md == 1) ? 2 : 1);
            2: return (md != 1) ? 1 : (m_pulse() ? 3 : 2);
            3: return m_halt() ? 4 : ((md != 1) ? 1 : 2);
            default: return (m_pulse() && int'(I_PC) <= MAX_PC) ? 3 : 4;
        endcase
    endfunction

    function automatic logic [23:0] m_next_disp();
        logic [31:0] word;
        if (m_phase == 4 && int'(I_PC) > MAX_PC)
            word = 32'(I_MEM_DATA_B);
        else
            word = (32'(I_PC) << 16) | 32'(I_RESULT_BUS);
`ifdef CR16_RUN_CTRL_CYCLE_COUNT_EN
        if (m_phase == 4) word[23:16] = m_count[7:0];
`endif
        return word[23:0];
    endfunction

    always @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            m_phase     <= 0;
            m_cold_seen <= 0;
            m_mask      <= 1'b0;
            m_hist      <= 4'b0000;
            m_disp      <= 24'h0;
            m_count     <= 32'h0;
        end else begin
            m_phase     <= m_next_phase();
            m_cold_seen <= (m_phase == 0) ? m_cold_seen + 1 : m_cold_seen;
            m_mask      <= (m_phase == 4) && (m_next_phase() == 3);
            m_hist      <= {m_hist[2:0], I_STEP};
            m_disp      <= m_next_disp();
            if (m_enable() && m_count != 32'hFFFF_FFFF) m_count <= m_count + 32'd1;
        end
    end

    // Compare the DUT against the model in the middle of every cycle.
    always @(negedge I_CLK) begin
        #2;
        if (I_NRESET) begin
            check("model_enable",  32'(O_CR16_ENABLE),  32'(m_enable()));
            check("model_state",   32'(O_STATE),        32'(m_phase));
            check("model_display", 32'(O_DISPLAY_BITS), 32'(m_disp));
`ifdef CR16_RUN_CTRL_CYCLE_COUNT_EN
            check("model_count",   O_CYCLE_COUNT,       m_count);
`endif
        end
    end

    // Hold reset for two cycles, release at a falling edge (cycle 1 begins).
    task automatic do_reset();
        I_NRESET = 1'b0;
        tick();
        tick();
        I_NRESET = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  mode;
        logic [15:0] brk;
        logic [15:0] pc;
        logic [15:0] res;
        logic        exp_en;
        logic [23:0] exp_disp;
        logic [2:0]  exp_state;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int first_en;
        int en_cnt;
        bit en_seen;
        bit left_halt;

        vecs[0] = '{2'b00, 16'h0000, 16'h0005, 16'h1234, 1'b1, 24'h051234, 3'd1};
        vecs[1] = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 24'h000000, 3'd1};
        vecs[2] = '{2'b00, 16'h0000, 16'h0014, 16'hFFFF, 1'b1, 24'h14FFFF, 3'd1};
        vecs[3] = '{2'b11, 16'h0000, 16'h0013, 16'hA5A5, 1'b1, 24'h13A5A5, 3'd1};
        vecs[4] = '{2'b10, 16'h0009, 16'h0008, 16'h00C3, 1'b1, 24'h0800C3, 3'd1};
        vecs[5] = '{2'b00, 16'h0000, 16'h0115, 16'h0042, 1'b0, 24'h150042, 3'd4};

        // ---- Test 1: warm-up timing and PC-limit halt, free-run ----
        do_reset();
        #3;
        check("t1_reset_state", 32'(O_STATE), 32'd0);
        check("t1_reset_disp",  32'(O_DISPLAY_BITS), 32'h0);
        check("t1_en_cycle1",   32'(O_CR16_ENABLE), 32'd0);
        tick(); #3;
        check("t1_en_cycle2",   32'(O_CR16_ENABLE), 32'd0);
        tick(); #3;
        check("t1_en_cycle3",   32'(O_CR16_ENABLE), 32'd1);
        check("t1_state_run",   32'(O_STATE), 32'd1);
        tick(); I_PC = 16'd20; #3;
        check("t1_en_pc_at_limit", 32'(O_CR16_ENABLE), 32'd1);
        tick(); I_PC = 16'd21; I_MEM_DATA_B = 16'hBEEF; #3;
        check("t1_en_pc_over", 32'(O_CR16_ENABLE), 32'd0);
        tick(); #3;
        check("t1_state_halt", 32'(O_STATE), 32'd4);
        check("t1_disp_last_run", 32'(O_DISPLAY_BITS), 32'h150000);
        tick(); #3;
        check("t1_disp_bram", 32'(O_DISPLAY_BITS), 32'h00BEEF);
        $display("[TB] test1 warm-up/limit halt done");

        // ---- Test 2: single-step mode ----
        I_PC = 16'd3; I_RUN_MODE = 2'b01; I_MEM_DATA_B = 16'h0;
        do_reset();
        tick(); tick(); #3;
        check("t2_state_wait", 32'(O_STATE), 32'd2);
        check("t2_en_wait", 32'(O_CR16_ENABLE), 32'd0);
        I_STEP = 1'b1;
        first_en = -1;
        en_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(); #3;
            if (O_CR16_ENABLE) begin
                en_cnt++;
                if (first_en < 0) first_en = k;
            end
        end
        check("t2_step_latency", 32'(first_en), 32'd4);
        check("t2_step_count",   32'(en_cnt),   32'd1);
        I_STEP = 1'b0;
        $display("[TB] test2 single-step done");

        // ---- Test 3: breakpoint halt and resume ----
        I_RUN_MODE = 2'b10; I_BREAK_PC = 16'd8; I_PC = 16'd5;
        do_reset();
        tick(); tick();
        I_PC = 16'd8; #3;
        check("t3_en_at_bp", 32'(O_CR16_ENABLE), 32'd0);
        tick(); #3;
        check("t3_state_halt", 32'(O_STATE), 32'd4);
        I_STEP = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 2) I_STEP = 1'b0;
            if (k == 5) I_PC = 16'd9;
            #3;
            if (k == 3) check("t3_still_halt", 32'(O_STATE), 32'd4);
            if (k == 4) begin
                check("t3_state_exec", 32'(O_STATE), 32'd3);
                check("t3_en_masked",  32'(O_CR16_ENABLE), 32'd1);
            end
            if (k == 5) begin
                check("t3_state_run", 32'(O_STATE), 32'd1);
                check("t3_en_run",    32'(O_CR16_ENABLE), 32'd1);
            end
        end
        $display("[TB] test3 breakpoint done");

        // ---- Test 4: sticky halt past the limit, async reset ----
        I_RUN_MODE = 2'b00; I_PC = 16'd0;
        do_reset();
        tick(); tick();
        I_PC = 16'd21;
        tick();
        en_seen = 1'b0;
        left_halt = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            I_STEP = ((k % 6) < 3);
            tick(); #3;
            if (O_CR16_ENABLE) en_seen = 1'b1;
            if (O_STATE != 3'd4) left_halt = 1'b1;
        end
        I_STEP = 1'b0;
        check("t4_no_enable", 32'(en_seen), 32'd0);
        check("t4_halt_sticky", 32'(left_halt), 32'd0);
        #1 I_NRESET = 1'b0;
        #1;
        check("t4_async_state", 32'(O_STATE), 32'd0);
        check("t4_async_en",    32'(O_CR16_ENABLE), 32'd0);
        I_PC = 16'd0;
        tick(); I_NRESET = 1'b1; #3;
        check("t4_rewarm_c1", 32'(O_CR16_ENABLE), 32'd0);
        tick(); #3;
        check("t4_rewarm_c2", 32'(O_CR16_ENABLE), 32'd0);
        tick(); #3;
        check("t4_rewarm_c3", 32'(O_CR16_ENABLE), 32'd1);
        $display("[TB] test4 sticky halt/reset done");

        // ---- Test 5: vector table while running ----
        I_PC = 16'd0;
        do_reset();
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            I_RUN_MODE = vecs[i].mode; I_BREAK_PC = vecs[i].brk;
            I_PC = vecs[i].pc; I_RESULT_BUS = vecs[i].res;
            #3;
            check($sformatf("vec%0d_en", i), 32'(O_CR16_ENABLE), 32'(vecs[i].exp_en));
            @(posedge I_CLK); #3;
            check($sformatf("vec%0d_disp", i), 32'(O_DISPLAY_BITS), 32'(vecs[i].exp_disp));
            check($sformatf("vec%0d_state", i), 32'(O_STATE), 32'(vecs[i].exp_state));
            $display("[TB] vec %0d pc=%h res=%h en=%0b disp=%h", i, I_PC, I_RESULT_BUS, O_CR16_ENABLE, O_DISPLAY_BITS);
        end
        tick(); I_MEM_DATA_B = 16'hBEEF;
        @(posedge I_CLK); #3;
`ifdef CR16_RUN_CTRL_CYCLE_COUNT_EN
        check("t5_disp_bram", 32'(O_DISPLAY_BITS[15:0]), 32'hBEEF);
`else
        check("t5_disp_bram", 32'(O_DISPLAY_BITS), 32'h00BEEF);
`endif

`ifdef CR16_RUN_CTRL_CYCLE_COUNT_EN
        // ---- Test 6: enabled-cycle counter ----
        I_RUN_MODE = 2'b00; I_PC = 16'd0; I_RESULT_BUS = 16'h0;
        do_reset();
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            I_PC = 16'(i + 1);
        end
        I_PC = 16'd21;
        tick(); tick(); #3;
        check("t6_count", O_CYCLE_COUNT, 32'd10);
        check("t6_disp_cnt", 32'(O_DISPLAY_BITS[23:16]), 32'h0A);
        $display("[TB] test6 cycle count=%0d", O_CYCLE_COUNT);
`endif

        // ---- Randomized episodes against the model ----
        for (int ep = 0; ep < 6; ep++) begin
            I_RUN_MODE = 2'($urandom_range(0, 3));
            I_BREAK_PC = 16'($urandom_range(0, 20));
            I_PC = 16'd0;
            I_STEP = 1'b0;
            do_reset();
            for (int c = 0; c < 500; c++) begin
                tick();
                if ($urandom_range(0, 149) == 0) begin
                    I_RUN_MODE = 2'($urandom_range(0, 3));
                    I_BREAK_PC = 16'($urandom_range(0, 20));
                end
                if ($urandom_range(0, 99) == 0)
                    I_PC = 16'($urandom_range(21, 40));
                else
                    I_PC = 16'($urandom_range(0, 20));
                I_RESULT_BUS = 16'($urandom);
                I_MEM_DATA_B = 16'($urandom);
                if ($urandom_range(0, 7) == 0) I_STEP = ~I_STEP;
            end
            $display("[TB] random episode %0d done, failures so far %0d", ep, n_fail);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
